// File: rtl/cache_arbiter_pkg.sv
// Shared cache types and defaults used by the arbiter, its bus interface and the bench.
// Line geometry is 32-byte lines, so the low five address bits never reach memory.
package cache_arbiter_pkg;

   localparam int LINE_WIDTH_DEF = 256;
   localparam int ADDR_WIDTH_DEF = 32;
   localparam int LINE_OFFSET_W  = 5;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      RECOVER
   } arb_state_e;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_e;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } pmem_op_e;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and the cacheline adaptor.
// The arbiter uses the slave view; whatever drives the caches and memory uses master.
interface cache_arbiter_if
   import cache_arbiter_pkg::*;
#(
   parameter int LINE_WIDTH = LINE_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

   logic                  i_read;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [LINE_WIDTH-1:0] i_rdata;
   logic                  i_resp;

   logic                  d_read;
   logic                  d_write;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [LINE_WIDTH-1:0] d_wdata;
   logic [LINE_WIDTH-1:0] d_rdata;
   logic                  d_resp;

   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_WIDTH-1:0] pmem_addr;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic [LINE_WIDTH-1:0] pmem_rdata;
   logic                  pmem_resp;

   modport slave (
      input  i_read, i_addr,
      input  d_read, d_write, d_addr, d_wdata,
      input  pmem_rdata, pmem_resp,
      output i_rdata, i_resp,
      output d_rdata, d_resp,
      output pmem_read, pmem_write, pmem_addr, pmem_wdata
   );

   modport master (
      output i_read, i_addr,
      output d_read, d_write, d_addr, d_wdata,
      output pmem_rdata, pmem_resp,
      input  i_rdata, i_resp,
      input  d_rdata, d_resp,
      input  pmem_read, pmem_write, pmem_addr, pmem_wdata
   );

endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto one cacheline adaptor,
// alternating grants on contention; memory strobes come only from latched registers.
module cache_arbiter
   import cache_arbiter_pkg::*;
#(
   parameter int LINE_WIDTH = LINE_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic            clk,
   input  logic            rst,
   cache_arbiter_if.slave  bus
);

   arb_state_e            state_q, state_d;
   grant_e                last_grant_q, last_grant_d;
   pmem_op_e              op_q, op_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

   logic d_req;
   logic grant_i;
   logic serving;

   assign d_req   = bus.d_read | bus.d_write;
   // icache wins alone, or on a tie when the dcache had the previous grant
   assign grant_i = bus.i_read & (~d_req | (last_grant_q == GNT_D));
   assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      bus.i_resp   = 1'b0;
      bus.i_rdata  = '0;
      bus.d_resp   = 1'b0;
      bus.d_rdata  = '0;

      unique case (state_q)
         IDLE: begin
            if (grant_i) begin
               state_d      = SERVE_I;
               last_grant_d = GNT_I;
               op_d         = OP_READ;
               addr_d       = bus.i_addr;
               addr_d[LINE_OFFSET_W-1:0] = '0;
            end else if (d_req) begin
               state_d      = SERVE_D;
               last_grant_d = GNT_D;
               op_d         = bus.d_write ? OP_WRITE : OP_READ;
               addr_d       = bus.d_addr;
               addr_d[LINE_OFFSET_W-1:0] = '0;
               wdata_d      = bus.d_wdata;
            end
         end
         SERVE_I: begin
            if (bus.pmem_resp) begin
               bus.i_resp  = 1'b1;
               bus.i_rdata = bus.pmem_rdata;
               state_d     = RECOVER;
            end
         end
         SERVE_D: begin
            if (bus.pmem_resp) begin
               bus.d_resp  = 1'b1;
               bus.d_rdata = bus.pmem_rdata;
               state_d     = RECOVER;
            end
         end
         // one dead cycle so the finished requester can drop its request
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.pmem_read  = serving && (op_q == OP_READ);
   assign bus.pmem_write = serving && (op_q == OP_WRITE);
   assign bus.pmem_addr  = addr_q;
   assign bus.pmem_wdata = wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_D;
         op_q         <= OP_READ;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized scoreboard bench for cache_arbiter: a transaction-order model predicts
// memory requests and cache responses; a responder and a monitor check them.
module tb_cache_arbiter;
   import cache_arbiter_pkg::*;

   localparam int LW      = LINE_WIDTH_DEF;
   localparam int AW      = ADDR_WIDTH_DEF;
   localparam int ROUNDS  = 60;
   localparam int TIMEOUT = 100;

   typedef struct {
      bit            is_d;
      bit            wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
   } txn_t;

   typedef struct {
      bit            is_d;
      logic [LW-1:0] rdata;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cache_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

   cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   txn_t          exp_txn[$];
   rsp_t          exp_rsp[$];
   int            checks      = 0;
   int            passes      = 0;
   bit            rounds_done = 1'b0;
   bit            last_was_d  = 1'b1;
   bit            ovr_en      = 1'b0;
   int            ovr_lat     = 0;
   logic [LW-1:0] ovr_data    = '0;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: actual %h required %h", name, act, req);
   endtask

   task automatic note_fail(input string name, input int act, input int req);
      checks++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
      return (a >> 5) << 5;
   endfunction

   // Monitor: every response must match the head of the expected-response queue.
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (!bus.i_resp) check("i_rdata_zero", bus.i_rdata, '0);
         if (!bus.d_resp) check("d_rdata_zero", bus.d_rdata, '0);
         if (bus.i_resp || bus.d_resp) begin
            check("resp_onehot", LW'(bus.i_resp & bus.d_resp), '0);
            if (exp_rsp.size() == 0) begin
               note_fail("unexpected_resp", int'({bus.i_resp, bus.d_resp}), 0);
            end else begin
               r = exp_rsp.pop_front();
               check("resp_to_dcache", LW'(bus.d_resp), LW'(r.is_d));
               check("resp_rdata", bus.d_resp ? bus.d_rdata : bus.i_rdata, r.rdata);
            end
         end
      end
   end

   task automatic pmem_responder();
      txn_t          t;
      rsp_t          r;
      int            lat;
      bit            known, extra, s_rd, s_wr;
      logic [AW-1:0] s_addr;
      logic [LW-1:0] data;
      while (!rounds_done) begin
         @(negedge clk);
         if (bus.pmem_read || bus.pmem_write) begin
            known = (exp_txn.size() != 0);
            if (!known) begin
               note_fail("unexpected_pmem_txn", int'(bus.pmem_addr), 0);
            end else begin
               t = exp_txn.pop_front();
               check("pmem_write", LW'(bus.pmem_write), LW'(t.wr));
               check("pmem_read", LW'(bus.pmem_read), LW'(!t.wr));
               check("pmem_addr", LW'(bus.pmem_addr), LW'(t.addr));
               if (t.wr) check("pmem_wdata", bus.pmem_wdata, t.wdata);
            end
            s_rd   = bus.pmem_read;
            s_wr   = bus.pmem_write;
            s_addr = bus.pmem_addr;
            lat    = ovr_en ? ovr_lat : int'($urandom_range(0, 4));
            repeat (lat) begin
               @(negedge clk);
               check("strobe_hold", LW'({bus.pmem_read, bus.pmem_write, bus.pmem_addr}),
                     LW'({s_rd, s_wr, s_addr}));
            end
            data = ovr_en ? ovr_data : rand_line();
            @(posedge clk); #1;
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = data;
            if (known) begin
               r.is_d  = t.is_d;
               r.rdata = data;
               exp_rsp.push_back(r);
            end
            extra = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (!extra) begin
               bus.pmem_resp  = 1'b0;
               bus.pmem_rdata = rand_line();
            end
            @(negedge clk);
            check("recover_no_strobe", LW'({bus.pmem_read, bus.pmem_write}), '0);
            if (extra) begin
               @(posedge clk); #1;
               bus.pmem_resp  = 1'b0;
               bus.pmem_rdata = rand_line();
            end
         end
      end
   endtask

   task automatic drive_rounds();
      txn_t          ti, td;
      int            pat, dop, cyc, gap;
      bit            pend_i, pend_d, ri, rd, strobe, early, dropped;
      logic [AW-1:0] ia, da;
      logic [LW-1:0] dw;
      for (int n = 0; n < ROUNDS; n++) begin
         // pat: 1 = icache only, 2 = dcache only, 3 = both at once
         pat   = (n == 0) ? 3 : (n == 1) ? 1 : (n == 2) ? 2 : int'($urandom_range(1, 3));
         dop   = (n == 2) ? 1 : int'($urandom_range(0, 2));
         early = (n > 2) && (pat != 3) && ($urandom_range(0, 1) == 1);
         ia    = (n == 1) ? AW'(32'h0000_0064) : AW'($urandom());
         da    = (n == 2) ? AW'(32'h8000_0020) : AW'($urandom());
         dw    = (n == 2) ? {(LW/16){16'h1234}} : rand_line();
         ti    = '{is_d: 1'b0, wr: 1'b0, addr: line_of(ia), wdata: '0};
         td    = '{is_d: 1'b1, wr: (dop != 0), addr: line_of(da), wdata: dw};
         if (pat == 1) begin
            exp_txn.push_back(ti);
            last_was_d = 1'b0;
         end else if (pat == 2) begin
            exp_txn.push_back(td);
            last_was_d = 1'b1;
         end else if (last_was_d) begin
            exp_txn.push_back(ti);
            exp_txn.push_back(td);
            last_was_d = 1'b1;
         end else begin
            exp_txn.push_back(td);
            exp_txn.push_back(ti);
            last_was_d = 1'b0;
         end
         ovr_en   = (n == 1);
         ovr_lat  = 3;
         ovr_data = {(LW/8){8'hAB}};
         bus.i_read  = (pat != 2);
         bus.i_addr  = ia;
         bus.d_read  = (pat != 1) && (dop != 1);
         bus.d_write = (pat != 1) && (dop != 0);
         bus.d_addr  = da;
         bus.d_wdata = dw;
         pend_i  = (pat != 2);
         pend_d  = (pat != 1);
         cyc     = 0;
         dropped = 1'b0;
         while ((pend_i || pend_d) && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            ri     = bus.i_resp;
            rd     = bus.d_resp;
            strobe = bus.pmem_read | bus.pmem_write;
            @(posedge clk); #1;
            if (ri) begin
               pend_i     = 1'b0;
               bus.i_read = 1'b0;
            end
            if (rd) begin
               pend_d      = 1'b0;
               bus.d_read  = 1'b0;
               bus.d_write = 1'b0;
            end
            if (early && strobe && !dropped && !(ri || rd)) begin
               bus.i_read  = 1'b0;
               bus.d_read  = 1'b0;
               bus.d_write = 1'b0;
               bus.i_addr  = AW'($urandom());
               bus.d_addr  = AW'($urandom());
               bus.d_wdata = rand_line();
               dropped     = 1'b1;
            end
         end
         if (pend_i || pend_d) begin
            note_fail("round_timeout", n, -1);
            break;
         end
         gap = int'($urandom_range(0, 3));
         repeat (gap) begin
            @(posedge clk); #1;
         end
      end
      ovr_en      = 1'b0;
      rounds_done = 1'b1;
   endtask

   initial begin
      logic [AW-1:0] ra;
      bus.i_read     = 1'b0;
      bus.i_addr     = '0;
      bus.d_read     = 1'b0;
      bus.d_write    = 1'b0;
      bus.d_addr     = '0;
      bus.d_wdata    = '0;
      bus.pmem_rdata = '0;
      bus.pmem_resp  = 1'b0;

      @(posedge clk);
      @(negedge clk);
      check("rst_pmem_read", LW'(bus.pmem_read), '0);
      check("rst_pmem_write", LW'(bus.pmem_write), '0);
      check("rst_pmem_addr", LW'(bus.pmem_addr), '0);
      check("rst_pmem_wdata", bus.pmem_wdata, '0);
      check("rst_resps", LW'({bus.i_resp, bus.d_resp}), '0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Writeback abandoned by reset two cycles into service
      ra          = AW'($urandom());
      bus.d_write = 1'b1;
      bus.d_addr  = ra;
      bus.d_wdata = rand_line();
      @(negedge clk);
      check("idle_no_strobe_yet", LW'(bus.pmem_write), '0);
      @(negedge clk);
      check("rstmid_write", LW'(bus.pmem_write), LW'(1'b1));
      check("rstmid_addr", LW'(bus.pmem_addr), LW'(line_of(ra)));
      @(negedge clk);
      check("rstmid_hold", LW'({bus.pmem_read, bus.pmem_write}), LW'(2'b01));
      @(posedge clk); #1;
      rst         = 1'b1;
      bus.d_write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_strobes_off", LW'({bus.pmem_read, bus.pmem_write}), '0);
      check("rstmid_addr_cleared", LW'(bus.pmem_addr), '0);
      last_was_d = 1'b1;

      // Memory response with nothing outstanding
      @(posedge clk); #1;
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = rand_line();
      repeat (3) begin
         @(negedge clk);
         check("spurious_idle_no_strobe", LW'({bus.pmem_read, bus.pmem_write}), '0);
      end
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;

      fork
         pmem_responder();
         drive_rounds();
      join

      repeat (3) @(negedge clk);
      check("txn_queue_drained", LW'(exp_txn.size()), '0);
      check("rsp_queue_drained", LW'(exp_rsp.size()), '0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
